// File: rtl/hs_mem_arb_pkg.sv
// Shared types and the round-robin pick function for the hs_mem arbiters.
// rr_pick is sized for the largest supported requester count so DPRAM variants can reuse it.
package hs_mem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at num (which need not be a power of 2).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input logic [RR_IDX_W-1:0]   ptr,
                                         input int                    num);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            if (!r.found && k < num) begin
                j = int'(ptr) + k;
                if (j >= num) j = j - num;
                if (valid[RR_IDX_W'(j)]) begin
                    r.found = 1'b1;
                    r.idx   = RR_IDX_W'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_mem_spram_rr_arb_if.sv
// Requester-side bus of the shared-RAM arbiter: per-port request lanes plus
// one-hot read strobes and a shared read-data bus.
interface hs_mem_spram_rr_arb_if #(
    parameter int  NUM_REQ    = 4,
    parameter int  ADDR_WIDTH = 4,
    parameter int  IDX_WIDTH  = 2,
    parameter type DATA_TYPE  = logic [7:0]
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_wen;
    logic [NUM_REQ-1:0]                 req_lock;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    DATA_TYPE                           req_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]                 rsp_valid;
    DATA_TYPE                           rsp_rdata;
    logic [IDX_WIDTH-1:0]               grant_idx;

    modport master (
        output req_valid, req_wen, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, grant_idx
    );

    modport slave (
        input  req_valid, req_wen, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, grant_idx
    );
endinterface

// File: rtl/hs_mem_spram_asyncrd.sv
// Single-port RAM: synchronous write, combinational read. Contents are not reset.
module hs_mem_spram_asyncrd #(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  DATA_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          wen,
    input  logic [$clog2(DATA_DEPTH)-1:0] addr,
    input  DATA_TYPE                      wdata,
    output DATA_TYPE                      rdata
);
    DATA_TYPE mem [DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (wen) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/hs_mem_spram_rr_arb.sv
// Round-robin arbiter sharing one async-read SPRAM among NUM_REQ requesters,
// with bounded lock (burst) grants and a registered one-cycle read response.
module hs_mem_spram_rr_arb
    import hs_mem_arb_pkg::*;
#(
    parameter type DATA_TYPE  = logic [7:0],
    parameter int  DATA_DEPTH = 16,
    parameter int  NUM_REQ    = 4,
    parameter int  MAX_LOCK   = 8
) (
    input logic                  clk,
    input logic                  rst,
    hs_mem_spram_rr_arb_if.slave bus
);
    localparam int                   ADDR_WIDTH = $clog2(DATA_DEPTH);
    localparam int                   IDX_WIDTH  = $clog2(NUM_REQ);
    localparam logic [7:0]           LOCK_MAX   = 8'(MAX_LOCK);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(NUM_REQ - 1);

    arb_state_e           state, state_nxt;
    logic [IDX_WIDTH-1:0] owner, owner_nxt, rr_ptr, g;
    logic [7:0]           lock_cnt, lock_cnt_nxt;
    rr_pick_t             pick;
    logic                 owner_go, acc, acc_wen, acc_rd;
    logic                 ram_wen;
    logic [ADDR_WIDTH-1:0] ram_addr;
    DATA_TYPE             ram_wdata, ram_rdata;

    // Grant selection: a locked owner that is still valid wins outright; otherwise
    // arbitrate in the same cycle, so dropping the owner costs no bubble.
    always_comb begin
        pick     = rr_pick(RR_MAX_REQ'(bus.req_valid), RR_IDX_W'(rr_ptr), NUM_REQ);
        owner_go = (state == LOCKED) && bus.req_valid[owner];
        g        = owner_go ? owner : IDX_WIDTH'(pick.idx);
        acc      = !rst && (owner_go || pick.found);
        acc_wen  = acc && bus.req_wen[g];
        acc_rd   = acc && !bus.req_wen[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = ARB;
        owner_nxt    = owner;
        lock_cnt_nxt = '0;
        if (acc && bus.req_lock[g]) begin
            if (owner_go) begin
                if (lock_cnt + 8'd1 < LOCK_MAX) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = lock_cnt + 8'd1;
                end
            end else if (MAX_LOCK > 1) begin
                state_nxt    = LOCKED;
                owner_nxt    = g;
                lock_cnt_nxt = 8'd1;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (acc) bus.req_ready[g] = 1'b1;
        ram_wen   = acc_wen;
        ram_addr  = bus.req_addr[g];
        ram_wdata = bus.req_wdata[g];
    end

    // rr_ptr follows every accept, so during a lock it naturally sits at owner+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.grant_idx <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= '0;
            if (acc) begin
                rr_ptr        <= (g == LAST_IDX) ? '0 : g + IDX_WIDTH'(1);
                bus.grant_idx <= g;
            end
            if (acc_rd) begin
                bus.rsp_valid[g] <= 1'b1;
                bus.rsp_rdata    <= ram_rdata;
            end
        end
    end

    hs_mem_spram_asyncrd #(
        .DATA_TYPE  (DATA_TYPE),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk   (clk),
        .wen   (ram_wen),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
endmodule
